// File: rtl/jam_cost_server.sv
// Cost-table responder for the job-assignment engine: loads an 8x8 cost matrix,
// serves same-cycle lookups, tracks the row-minimum lower bound and captures the engine result.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_LOAD  | accepting table entries, engine held in reset, reads return 0
// ST_SERVE | table complete, serving lookups, counting serve cycles
// ST_DONE  | engine result captured, lookups still served, counter frozen
module jam_cost_server #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             clear,
   input  logic             load_valid,
   input  logic [6:0]       load_data,
   output logic             load_ready,
   output logic             table_ready,
   input  logic [2:0]       W,
   input  logic [2:0]       J,
   output logic [6:0]       Cost,
   input  logic             Valid,
   input  logic [9:0]       MinCost,
   input  logic [3:0]       MatchCount,
   output logic [9:0]       LowerBound,
   output logic [CNT_W-1:0] serve_cycles,
   output logic             done,
   output logic [9:0]       result_min,
   output logic [3:0]       result_match
);

   typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_t;

   state_t     state, state_nxt;
   logic [5:0] idx;
   logic [6:0] rmin, rmin_nxt;
   logic [9:0] lb_acc;
   logic       accept, capture;
   logic [6:0] cost_mem [64];

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) state <= ST_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_LOAD: begin
            accept = load_valid && !clear;
            if (accept && idx == 6'd63) state_nxt = ST_SERVE;
         end
         ST_SERVE: begin
            if (Valid) begin
               capture   = !clear;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_DONE;
         default: state_nxt = ST_LOAD;
      endcase
      if (clear) state_nxt = ST_LOAD;
   end

   // First entry of a row restarts the running minimum.
   assign rmin_nxt = (idx[2:0] == 3'd0 || load_data < rmin) ? load_data : rmin;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         idx          <= '0;
         rmin         <= '0;
         lb_acc       <= '0;
         serve_cycles <= '0;
         result_min   <= '0;
         result_match <= '0;
      end else if (clear) begin
         idx          <= '0;
         rmin         <= '0;
         lb_acc       <= '0;
         serve_cycles <= '0;
         result_min   <= '0;
         result_match <= '0;
      end else begin
         if (accept) begin
            idx  <= idx + 6'd1;
            rmin <= rmin_nxt;
            if (idx[2:0] == 3'd7) lb_acc <= lb_acc + {3'b000, rmin_nxt};
         end
         if (state == ST_SERVE && serve_cycles != {CNT_W{1'b1}})
            serve_cycles <= serve_cycles + 1'b1;
         if (capture) begin
            result_min   <= MinCost;
            result_match <= MatchCount;
         end
      end
   end

   // Table storage has no reset; LOAD masks reads until a full load completes.
   always_ff @(posedge CLK) begin
      if (accept) cost_mem[idx] <= load_data;
   end

   assign load_ready  = (state == ST_LOAD);
   assign table_ready = (state != ST_LOAD);
   assign done        = (state == ST_DONE);
   assign Cost        = (state == ST_LOAD) ? 7'd0 : cost_mem[{W, J}];
   assign LowerBound  = (state == ST_LOAD) ? 10'd0 : lb_acc;

endmodule

// File: doc/jam_cost_server.md
# jam_cost_server

Cost-table responder for the job-assignment engine. Holds the 8×8 worker/job cost matrix and answers the engine's `W`/`J` lookups with a same-cycle `Cost`. A host fills the table through a valid/ready load port. The block then holds the engine in reset until the table is complete, computes a row-minimum lower bound during loading, and captures the engine's result when the engine raises `Valid`.

## Interface
Parameters:
- `CNT_W`, default 16: width of the serve-cycle counter.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart; returns the block to loading.
- `load_valid`  in  1  host is presenting a cost entry.
- `load_data`  in  7  cost entry, row-major order (index = W*8+J).
- `load_ready`  out  1  block accepts an entry this cycle.
- `table_ready`  out  1  table is complete; drive the engine reset with `~table_ready`.
- `W`  in  3  worker index from the engine.
- `J`  in  3  job index from the engine.
- `Cost`  out  7  table[W*8+J], combinational.
- `Valid`  in  1  engine result valid.
- `MinCost`  in  10  engine minimum cost.
- `MatchCount`  in  4  engine match count.
- `LowerBound`  out  10  sum of the 8 row minima.
- `serve_cycles`  out  CNT_W  number of cycles spent in SERVE, saturating.
- `done`  out  1  engine result has been captured.
- `result_min`  out  10  captured `MinCost`.
- `result_match`  out  4  captured `MatchCount`.

## Operation
States and transitions:
- LOAD → SERVE after the 64th accepted entry.
- SERVE → DONE when `Valid`=1.
- DONE holds until `clear`.
- `clear` from any state → LOAD.

LOAD:
- `load_ready`=1.
- An entry is accepted on an edge with `load_valid`&&`load_ready`. It is written to table[idx], and the 6-bit `idx` increments.
- Running row minimum `rmin`:
  - On accept with J-part (`idx[2:0]`)=0: `rmin` ← data.
  - On any other accept: `rmin` ← min(`rmin`, data).
  - On accept with `idx[2:0]`=7: `lb_acc` ← `lb_acc` + min(`rmin`, data).
- `lb_acc` is 10 bits and never overflows (max 8×127 = 1016).
- On accept with `idx`=63: next state is SERVE and `idx` wraps to 0.

SERVE and DONE:
- `Cost` = table[{W,J}].
- `LowerBound` = `lb_acc`.

LOAD (read side):
- `Cost` = 0 regardless of `W`/`J`.
- `LowerBound` = 0.

SERVE:
- `serve_cycles` increments each cycle and saturates at all-ones.
- `Valid`=1: capture `MinCost`/`MatchCount` into `result_min`/`result_match` and go to DONE.

DONE:
- `done`=1.
- `Valid` is ignored.
- The counter freezes.
- `Cost` keeps serving.

`clear`:
- Clears `idx`, `lb_acc`, `rmin`, `serve_cycles`, `done`, `result_min` and `result_match`.
- Table contents are kept, but are unreachable until overwritten by the next load.

## Timing
Reset (`RST_n`=0) values:
- State = LOAD.
- `load_ready`=1, `table_ready`=0, `Cost`=0, `LowerBound`=0, `serve_cycles`=0, `done`=0, `result_min`=0, `result_match`=0.
- Table contents are undefined after reset. Nothing is readable until a full load completes.

Load and serve:
- Load throughput is 1 entry per cycle. A gap in `load_valid` stalls without losing position.
- The edge that accepts entry 63 moves the block to SERVE. `table_ready`=1 and `load_ready`=0 are visible in the following cycle.
- `Cost` has zero latency: a `W`/`J` change is reflected in the same cycle, before the next edge.

Engine result:
- On the edge where `Valid`=1 in SERVE: `done`, `result_min` and `result_match` are updated and visible the next cycle.
- A `Valid` pulse in LOAD is ignored.

Simultaneous events:
- `clear` with an accepted load: `clear` wins and the entry is dropped. `load_ready` stays 1.
- `clear` with `Valid` in SERVE: `clear` wins and nothing is captured.
- `clear` with the 64th accept: the block stays in LOAD with `idx`=0.

Reset mid-load discards progress. The next load restarts at `idx`=0.

## Test plan
- **Ramp load.** Load cost = W+J with `load_valid` held high for 64 cycles.
  - `table_ready` rises on cycle 65.
  - `LowerBound`=28.
  - W=3,J=5 → `Cost`=8.
  - W=7,J=7 → `Cost`=14.
- **Stalled load.** Same data with `load_valid` toggled every other cycle.
  - `table_ready` rises only after the 64th accept (~128 cycles).
  - Same `LowerBound`/`Cost` values as the ramp load.
- **Saturated load.** Load all entries as 127.
  - `LowerBound`=1016.
  - Any W,J → `Cost`=127.
  - Before loading completes, any W,J → `Cost`=0.
- **Result capture.** After a load, run 10 cycles in SERVE, then pulse `Valid` with `MinCost`=300, `MatchCount`=2.
  - `done`=1, `result_min`=300, `result_match`=2, `serve_cycles`=10, frozen afterwards.
  - A second `Valid` pulse with `MinCost`=5 leaves `result_min`=300.
- **Clear collisions.**
  - `clear` on the same edge as the 40th accept: the next accept writes index 0, and `LowerBound` later reflects only the new data.
  - `clear` together with `Valid`: `done` stays 0 and the state is LOAD.
- **Mid-load reset.** Assert `RST_n`=0 at entry 30, then reload a full table.
  - `table_ready` rises after exactly 64 new accepts.
  - All outputs take their reset values during reset.
